rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (WEN/wsel/wdata) among NREQ writeback requesters, e.g. ALU, load unit and tensor-core result drain.
- Round-robin arbitration with valid/ready handshake; registered write stage, so the regfile sees one write per cycle, one cycle after grant.
- Contains a 32-entry busy scoreboard: destinations are reserved at issue and released when their write reaches the port. Issue logic queries it for RAW hazards.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- WORD_W, 32, data width; matches regfile word
- NREGS, 32, architectural registers; select width is log2(NREGS) = 5

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_sel  in  NREQ*5  destination register per requester, packed, i at [5i+4:5i]
- req_data  in  NREQ*WORD_W  write data per requester, packed
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready
- WEN  out  1  regfile write enable
- wsel  out  5  regfile write select
- wdata  out  WORD_W  regfile write data
- rsv_valid  in  1  issue stage reserves a destination this cycle
- rsv_sel  in  5  register being reserved
- chk_sel1  in  5  source 1 to check
- chk_sel2  in  5  source 2 to check
- chk_busy1  out  1  scoreboard bit for chk_sel1 (combinational)
- chk_busy2  out  1  scoreboard bit for chk_sel2 (combinational)
- pending_cnt  out  6  number of busy registers

Behaviour:
- Reset (async, nRST low):
  - WEN=0, wsel=0, wdata=0.
  - Scoreboard all 0; pending_cnt=0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - req_ready follows the combinational rule below (0 when no valid).
  - Reset mid-transfer discards any staged write; no WEN occurs.
- Arbitration (combinational):
  - Search order starts at pointer+1 mod NREQ.
  - The first requester with valid is granted; exactly that req_ready bit is 1, all others 0.
  - With no valid, req_ready=0.
  - ready depends on valid; valid must not depend on ready.
  - Requesters hold valid/sel/data stable until ready.
- Pointer update: on a grant, pointer <= granted index at the clock edge. With no grant, the pointer is held.
- Write stage, registered, 1-cycle latency:
  - Grant in cycle T gives WEN=1 in cycle T+1, with wsel/wdata latched from the granted requester. The write lands in the regfile at the end of T+1.
  - WEN is suppressed (0) if the granted sel == 0; the handshake still completes.
  - With no grant in T, WEN=0 in T+1; wsel/wdata hold their previous values.
  - Throughput: one write per cycle, no backpressure from the regfile.
- Scoreboard, 32 bits, bit 0 hardwired 0:
  - Set: at a clock edge with rsv_valid and rsv_sel != 0, busy[rsv_sel] <= 1.
  - Clear: at the clock edge ending a cycle with WEN=1, busy[wsel] <= 0.
  - Same register set and cleared in the same cycle: set wins (new reservation of the same register).
  - Reserving an already-busy register is legal; busy stays 1 (single bit, not counted).
  - A write to a non-busy register is legal; no change, no error.
  - chk_busy1 = busy[chk_sel1]; chk_busy2 = busy[chk_sel2]. These are purely combinational from current state; there is no bypass of same-cycle set or clear.
- pending_cnt: registered popcount of the scoreboard, updated at the same edge as the bits. Range 0..31.

Test Plan:
- Reset, then req_valid=001, sel=5, data=0xDEADBEEF -> ready=001 in cycle 0; cycle 1 WEN=1, wsel=5, wdata=0xDEADBEEF; cycle 2 WEN=0.
- All three valid, held for 4 cycles, distinct sel 1/2/3 (each requester drops valid after its grant and re-asserts immediately) -> grants in order 0,1,2,0; WEN every cycle from cycle 1 with wsel 1,2,3,1.
- Requester 1 has sel=0, data=0x1234, and is the only valid -> ready=010; next cycle WEN=0, pointer=1, so the next simultaneous 0/1/2 request grants requester 2 first.
- rsv_valid, sel=7 at cycle 0 -> chk_sel1=7 gives chk_busy1=1 and pending_cnt=1 from cycle 1; write to 7 granted at cycle 3 -> WEN cycle 4; busy[7]=0 and pending_cnt=0 from cycle 5.
- Reserve sel=9 in the same cycle that WEN=1 with wsel=9 -> busy[9] remains 1 and pending_cnt is unchanged; rsv sel=0 -> no bit set.
- Assert nRST low mid-cycle while a grant is staged (WEN about to rise) -> WEN=0 immediately, scoreboard cleared, pending_cnt=0, pointer=NREQ-1; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the single regfile write port among
// NREQ writeback requesters, with a registered write stage and a busy
// scoreboard for RAW hazard checks at issue.
//
// Ports:
//   CLK, nRST                   clock, async active-low reset
//   req_valid/req_sel/req_data  per-requester write request (packed)
//   req_ready                   one-hot grant, combinational from req_valid
//   WEN/wsel/wdata              registered regfile write port
//   rsv_valid/rsv_sel           destination reservation from issue
//   chk_sel1/2, chk_busy1/2     combinational scoreboard lookups
//   pending_cnt                 registered count of busy registers

module rf_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int WORD_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*5-1:0]      req_sel,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   WEN,
    output logic [4:0]             wsel,
    output logic [WORD_W-1:0]      wdata,
    input  logic                   rsv_valid,
    input  logic [4:0]             rsv_sel,
    input  logic [4:0]             chk_sel1,
    input  logic [4:0]             chk_sel2,
    output logic                   chk_busy1,
    output logic                   chk_busy2,
    output logic [5:0]             pending_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     idx;
    logic              found;
    logic [4:0]        g_sel;
    logic [WORD_W-1:0] g_data;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nx;
    logic [5:0]        cnt_nx;

    // Search starts one past the last winner, so the last winner
    // has lowest priority next time.
    always_comb begin
        req_ready = '0;
        gnt_idx   = ptr;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                gnt_idx        = idx;
                req_ready[idx] = 1'b1;
            end
        end
    end

    assign g_sel  = req_sel[int'(gnt_idx)*5 +: 5];
    assign g_data = req_data[int'(gnt_idx)*WORD_W +: WORD_W];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr   <= PW'(NREQ - 1);
            WEN   <= 1'b0;
            wsel  <= '0;
            wdata <= '0;
        end else if (found) begin
            ptr   <= gnt_idx;
            // r0 writes complete the handshake but never reach the regfile
            WEN   <= (g_sel != 5'd0);
            wsel  <= g_sel;
            wdata <= g_data;
        end else begin
            WEN <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle re-reservation wins.
    always_comb begin
        busy_nx = busy;
        if (WEN) begin
            busy_nx[wsel] = 1'b0;
        end
        if (rsv_valid && rsv_sel != 5'd0) begin
            busy_nx[rsv_sel] = 1'b1;
        end
        busy_nx[0] = 1'b0;
        cnt_nx = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nx = cnt_nx + 6'(busy_nx[i]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nx;
            pending_cnt <= cnt_nx;
        end
    end

    assign chk_busy1 = busy[chk_sel1];
    assign chk_busy2 = busy[chk_sel2];

endmodule
